jelly_ring_bus_responder: RTL

JELLY_RING_BUS_RESPONDER -- requirements
Module: jelly_ring_bus_responder

---
 rtl/jelly_ring_bus_id_queue.sv | 65 ++++++
 rtl/jelly_ring_bus_responder.sv | 93 +++++++++
 2 files changed

// File: rtl/jelly_ring_bus_id_queue.sv
// Synchronous FIFO holding the requester IDs of commands still awaiting a response.
// Depth is 2**PTR_WIDTH; the head is read combinationally from the storage array.
module jelly_ring_bus_id_queue #(
    parameter int unsigned ID_WIDTH  = 3,
    parameter int unsigned PTR_WIDTH = 2
) (
    input  logic                 reset,
    input  logic                 clk,
    input  logic                 cke,
    input  logic                 push,
    input  logic [ID_WIDTH-1:0]  push_id,
    input  logic                 pop,
    output logic [ID_WIDTH-1:0]  pop_id,
    output logic                 full,
    output logic                 empty,
    output logic [PTR_WIDTH:0]   count
);

    localparam int unsigned DEPTH = 1 << PTR_WIDTH;
    localparam int unsigned CNT_W = PTR_WIDTH + 1;

    logic [ID_WIDTH-1:0]  mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]     cnt;
    logic                 push_en;
    logic                 pop_en;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign push_en = cke & push & ~full;
    assign pop_en  = cke & pop & ~empty;

    assign full   = (cnt == CNT_W'(DEPTH));
    assign empty  = (cnt == '0);
    assign count  = cnt;
    assign pop_id = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= push_id;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            case ({push_en, pop_en})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/jelly_ring_bus_responder.sv
// Ring-bus responder: forwards ring requests to local logic as commands and returns
// local responses to the originating requester, in order, via an outstanding-ID queue.
module jelly_ring_bus_responder #(
    parameter int unsigned S_ID_WIDTH      = 3,
    parameter int unsigned DOWN_DATA_WIDTH = 32,
    parameter int unsigned UP_DATA_WIDTH   = 16,
    parameter int unsigned QUE_PTR_WIDTH   = 2
) (
    input  logic                       reset,
    input  logic                       clk,
    input  logic                       cke,

    input  logic [S_ID_WIDTH-1:0]      ring_down_id_from,
    input  logic [DOWN_DATA_WIDTH-1:0] ring_down_data,
    input  logic                       ring_down_valid,
    output logic                       ring_down_ready,

    output logic [S_ID_WIDTH-1:0]      ring_up_id_to,
    output logic [UP_DATA_WIDTH-1:0]   ring_up_data,
    output logic                       ring_up_valid,
    input  logic                       ring_up_ready,

    output logic [DOWN_DATA_WIDTH-1:0] m_cmd_data,
    output logic                       m_cmd_valid,
    input  logic                       m_cmd_ready,

    input  logic [UP_DATA_WIDTH-1:0]   s_res_data,
    input  logic                       s_res_valid,
    output logic                       s_res_ready
);

    logic                    que_full;
    logic                    que_empty;
    logic [QUE_PTR_WIDTH:0]  que_count;
    logic [S_ID_WIDTH-1:0]   que_head;
    logic                    push;
    logic                    pop;
    logic                    unused_que_count;

    // Readies use only registered state and the local handshakes, so ring_up_ready
    // never reaches ring_down_ready; full/empty are pre-edge so there is no bypass.
    assign ring_down_ready = cke & ~que_full  & (~m_cmd_valid   | m_cmd_ready);
    assign s_res_ready     = cke & ~que_empty & (~ring_up_valid | ring_up_ready);

    assign push = ring_down_valid & ring_down_ready;
    assign pop  = s_res_valid & s_res_ready;

    assign unused_que_count = ^que_count;

    jelly_ring_bus_id_queue #(
        .ID_WIDTH  (S_ID_WIDTH),
        .PTR_WIDTH (QUE_PTR_WIDTH)
    ) u_id_queue (
        .reset   (reset),
        .clk     (clk),
        .cke     (cke),
        .push    (push),
        .push_id (ring_down_id_from),
        .pop     (pop),
        .pop_id  (que_head),
        .full    (que_full),
        .empty   (que_empty),
        .count   (que_count)
    );

    // Command and response output stages; a new load wins over a same-cycle accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cmd_data    <= '0;
            m_cmd_valid   <= 1'b0;
            ring_up_id_to <= '0;
            ring_up_data  <= '0;
            ring_up_valid <= 1'b0;
        end else if (cke) begin
            if (m_cmd_valid && m_cmd_ready) begin
                m_cmd_valid <= 1'b0;
            end
            if (push) begin
                m_cmd_data  <= ring_down_data;
                m_cmd_valid <= 1'b1;
            end
            if (ring_up_valid && ring_up_ready) begin
                ring_up_valid <= 1'b0;
            end
            if (pop) begin
                ring_up_id_to <= que_head;
                ring_up_data  <= s_res_data;
                ring_up_valid <= 1'b1;
            end
        end
    end

endmodule
